// File: rtl/cpu_machine_if.sv
// -----------------------------------------------------------------------------
// cpu_machine_if
//   Memory bus between the cpu_machine core and its two memories.
//
//   Signals
//     imem_addr   core -> I_MEM   8-bit instruction address (PC)
//     imem_rdata  I_MEM -> core   16-bit instruction word (combinational read)
//     dmem_addr   core -> D_MEM   8-bit data address
//     dmem_wdata  core -> D_MEM   8-bit write data
//     dmem_we     core -> D_MEM   write enable, sampled on the rising clk edge
//     dmem_rdata  D_MEM -> core   8-bit read data (combinational read)
//
//   Modports
//     master  CPU core
//     slave   data memory
//     rom     instruction memory (read-only as seen from the core)
// -----------------------------------------------------------------------------
interface cpu_machine_if;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic [7:0]  dmem_addr;
    logic [7:0]  dmem_wdata;
    logic        dmem_we;
    logic [7:0]  dmem_rdata;

    modport master (
        output imem_addr,
        output dmem_addr,
        output dmem_wdata,
        output dmem_we,
        input  imem_rdata,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_we,
        output dmem_rdata
    );

    modport rom (
        input  imem_addr,
        output imem_rdata
    );
endinterface

// File: rtl/cpu_machine.sv
// -----------------------------------------------------------------------------
// cpu_machine
//   Self-contained 8-bit single-cycle computer: CPU core, 256 x 16 instruction
//   memory and 256 x 8 data memory. After reset the core fetches from address
//   0 and commits one instruction per rising clk edge until it executes HLT.
//
//   Top-level ports
//     clk          input   system clock, all state updates on the rising edge
//     reset        input   asynchronous, active-high reset
//     halted       output  high once HLT has executed (registered, clean edge)
//     instr_count  output  16-bit executed-instruction counter
//                          (only when INSTR_COUNT_EN is defined)
//
//   Build option
//     INSTR_COUNT_EN  adds the instr_count port and its counter.
//
//   Hierarchy
//     I_MEM          cpu_imem     array Memory[0:255] of 16 bits
//     D_MEM          cpu_dmem     array Memory[0:255] of 8 bits
//     CPU_           cpu_core     state, flags, cpu_halted
//     CPU_.CPU_regs  cpu_regfile  regA..regH (codes 0..7)
//
//   Instruction word: op=[15:12] rd=[11:9] rs=[8:6] imm8=[7:0]
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// cpu_imem: instruction memory, combinational read.
//   clk          input   clock for the load port
//   load_we_i    input   program-load write enable (tied off at the top)
//   load_addr_i  input   program-load address
//   load_data_i  input   program-load data
//   bus          rom     instruction fetch side of the memory bus
// -----------------------------------------------------------------------------
module cpu_imem #(
    parameter int IMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        load_we_i,
    input  logic [7:0]  load_addr_i,
    input  logic [15:0] load_data_i,
    cpu_machine_if.rom  bus
);
    logic [15:0] Memory [0:IMEM_DEPTH-1];

    // NOTE: storage arrays get no reset branch; clearing 256 words in one
    // cycle would need a flop-based array instead of RAM, and contents must
    // survive reset anyway. Non-blocking (<=) is used for every clocked write
    // so all registers update from the same pre-edge values.
    // Plain always (not always_ff) so the array may also be preloaded from
    // outside the design.
    always @(posedge clk) begin
        if (load_we_i) begin
            Memory[load_addr_i] <= load_data_i;
        end
    end

    assign bus.imem_rdata = Memory[bus.imem_addr];
endmodule

// -----------------------------------------------------------------------------
// cpu_dmem: data memory, combinational read, synchronous write.
//   clk  input  write clock
//   bus  slave  data side of the memory bus
// -----------------------------------------------------------------------------
module cpu_dmem #(
    parameter int DMEM_DEPTH = 256
) (
    input  logic          clk,
    cpu_machine_if.slave  bus
);
    logic [7:0] Memory [0:DMEM_DEPTH-1];

    always @(posedge clk) begin
        if (bus.dmem_we) begin
            Memory[bus.dmem_addr] <= bus.dmem_wdata;
        end
    end

    assign bus.dmem_rdata = Memory[bus.dmem_addr];
endmodule

// -----------------------------------------------------------------------------
// cpu_regfile: eight 8-bit registers, two combinational read ports, one
// synchronous write port. All registers clear on reset.
//   clk, rst     input   clock, asynchronous active-high reset
//   we_i         input   write enable
//   waddr_i      input   write register code
//   wdata_i      input   write data
//   raddr_a_i    input   read port A register code (rd)
//   raddr_b_i    input   read port B register code (rs)
//   rdata_a_o    output  read port A data
//   rdata_b_o    output  read port B data
// -----------------------------------------------------------------------------
module cpu_regfile (
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic [2:0] waddr_i,
    input  logic [7:0] wdata_i,
    input  logic [2:0] raddr_a_i,
    input  logic [2:0] raddr_b_i,
    output logic [7:0] rdata_a_o,
    output logic [7:0] rdata_b_o
);
    logic [7:0] regA, regB, regC, regD, regE, regF, regG, regH;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regA <= 8'd0;
            regB <= 8'd0;
            regC <= 8'd0;
            regD <= 8'd0;
            regE <= 8'd0;
            regF <= 8'd0;
            regG <= 8'd0;
            regH <= 8'd0;
        end else if (we_i) begin
            case (waddr_i)
                3'd0: regA <= wdata_i;
                3'd1: regB <= wdata_i;
                3'd2: regC <= wdata_i;
                3'd3: regD <= wdata_i;
                3'd4: regE <= wdata_i;
                3'd5: regF <= wdata_i;
                3'd6: regG <= wdata_i;
                default: regH <= wdata_i;
            endcase
        end
    end

    // NOTE: every output of a combinational block gets a default before the
    // case, otherwise an uncovered path would infer a latch.
    always_comb begin
        rdata_a_o = regA;
        rdata_b_o = regA;
        case (raddr_a_i)
            3'd1: rdata_a_o = regB;
            3'd2: rdata_a_o = regC;
            3'd3: rdata_a_o = regD;
            3'd4: rdata_a_o = regE;
            3'd5: rdata_a_o = regF;
            3'd6: rdata_a_o = regG;
            3'd7: rdata_a_o = regH;
            default: ;
        endcase
        case (raddr_b_i)
            3'd1: rdata_b_o = regB;
            3'd2: rdata_b_o = regC;
            3'd3: rdata_b_o = regD;
            3'd4: rdata_b_o = regE;
            3'd5: rdata_b_o = regF;
            3'd6: rdata_b_o = regG;
            3'd7: rdata_b_o = regH;
            default: ;
        endcase
    end
endmodule

// -----------------------------------------------------------------------------
// cpu_core: fetch, decode, execute and commit in one cycle.
//   clk, rst       input   clock, asynchronous active-high reset
//   bus            master  instruction and data memory bus
//   halted_o       output  copy of cpu_halted
//   instr_count_o  output  executed instruction count (INSTR_COUNT_EN only)
// -----------------------------------------------------------------------------
module cpu_core (
    input  logic           clk,
    input  logic           rst,
    cpu_machine_if.master  bus,
`ifdef INSTR_COUNT_EN
    output logic [15:0]    instr_count_o,
`endif
    output logic           halted_o
);
    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_LDI = 4'h1, OP_MOV = 4'h2, OP_ADD = 4'h3,
        OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR  = 4'h6, OP_XOR = 4'h7,
        OP_LD  = 4'h8, OP_ST  = 4'h9, OP_LDR = 4'hA, OP_STR = 4'hB,
        OP_JMP = 4'hC, OP_JZ  = 4'hD, OP_JC  = 4'hE, OP_HLT = 4'hF
    } op_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       z_q, z_d;
    logic       c_q, c_d;
    logic       cpu_halted;

    logic [15:0] instr;
    op_e         op;
    logic [2:0]  rd, rs;
    logic [7:0]  imm;
    logic [7:0]  rd_val, rs_val;

    logic        rf_we;
    logic [7:0]  rf_wdata;
    logic        is_alu;
    logic [8:0]  alu;     // bit 8 is carry (ADD) or borrow (SUB)
    logic [7:0]  dmem_addr, dmem_wdata;
    logic        dmem_we;

    assign bus.imem_addr = pc_q;
    assign instr = bus.imem_rdata;
    assign op    = op_e'(instr[15:12]);
    assign rd    = instr[11:9];
    assign rs    = instr[8:6];
    assign imm   = instr[7:0];

    cpu_regfile CPU_regs (
        .clk       (clk),
        .rst       (rst),
        .we_i      (rf_we),
        .waddr_i   (rd),
        .wdata_i   (rf_wdata),
        .raddr_a_i (rd),
        .raddr_b_i (rs),
        .rdata_a_o (rd_val),
        .rdata_b_o (rs_val)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            pc_q    <= 8'd0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            z_q     <= z_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q + 8'd1;   // 8-bit, wraps 255 -> 0
        z_d        = z_q;
        c_d        = c_q;
        rf_we      = 1'b0;
        rf_wdata   = rd_val;
        is_alu     = 1'b0;
        alu        = 9'd0;
        dmem_addr  = imm;
        dmem_wdata = rd_val;
        dmem_we    = 1'b0;

        if (state_q == ST_HALT) begin
            pc_d = pc_q;
        end else begin
            case (op)
                OP_NOP: ;
                OP_LDI: begin
                    rf_we    = 1'b1;
                    rf_wdata = imm;
                end
                OP_MOV: begin
                    rf_we    = 1'b1;
                    rf_wdata = rs_val;
                end
                OP_ADD: begin
                    is_alu = 1'b1;
                    alu    = {1'b0, rd_val} + {1'b0, rs_val};
                end
                OP_SUB: begin
                    is_alu = 1'b1;
                    alu    = {1'b0, rd_val} - {1'b0, rs_val};
                end
                OP_AND: begin
                    is_alu = 1'b1;
                    alu    = {1'b0, rd_val & rs_val};
                end
                OP_OR: begin
                    is_alu = 1'b1;
                    alu    = {1'b0, rd_val | rs_val};
                end
                OP_XOR: begin
                    is_alu = 1'b1;
                    alu    = {1'b0, rd_val ^ rs_val};
                end
                OP_LD: begin
                    rf_we    = 1'b1;
                    rf_wdata = bus.dmem_rdata;
                end
                OP_ST: begin
                    dmem_we = 1'b1;
                end
                OP_LDR: begin
                    dmem_addr = rs_val;
                    rf_we     = 1'b1;
                    rf_wdata  = bus.dmem_rdata;
                end
                OP_STR: begin
                    dmem_addr = rs_val;
                    dmem_we   = 1'b1;
                end
                OP_JMP: pc_d = imm;
                OP_JZ:  if (z_q) pc_d = imm;
                OP_JC:  if (c_q) pc_d = imm;
                OP_HLT: begin
                    pc_d    = pc_q;
                    state_d = ST_HALT;
                end
                default: ;
            endcase

            if (is_alu) begin
                rf_we    = 1'b1;
                rf_wdata = alu[7:0];
                z_d      = (alu[7:0] == 8'd0);
                c_d      = alu[8];
            end
        end
    end

    assign bus.dmem_addr  = dmem_addr;
    assign bus.dmem_wdata = dmem_wdata;
    assign bus.dmem_we    = dmem_we;

    // Decoded straight from a flop, so it rises cleanly on the HLT edge.
    assign cpu_halted = (state_q == ST_HALT);
    assign halted_o   = cpu_halted;

`ifdef INSTR_COUNT_EN
    logic [15:0] icount_q;

    // Counts every edge taken in RUN, which includes the HLT edge itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icount_q <= 16'd0;
        end else if (state_q == ST_RUN) begin
            icount_q <= icount_q + 16'd1;
        end
    end

    assign instr_count_o = icount_q;
`endif
endmodule

// -----------------------------------------------------------------------------
// cpu_machine: top level, wires the core to both memories.
// -----------------------------------------------------------------------------
module cpu_machine #(
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256
) (
    input  logic        clk,
    input  logic        reset,
`ifdef INSTR_COUNT_EN
    output logic [15:0] instr_count,
`endif
    output logic        halted
);
    cpu_machine_if bus ();

    // The program-load port is unused here; programs are preloaded into the
    // array directly.
    cpu_imem #(.IMEM_DEPTH(IMEM_DEPTH)) I_MEM (
        .clk         (clk),
        .load_we_i   (1'b0),
        .load_addr_i (8'd0),
        .load_data_i (16'd0),
        .bus         (bus.rom)
    );

    cpu_dmem #(.DMEM_DEPTH(DMEM_DEPTH)) D_MEM (
        .clk (clk),
        .bus (bus.slave)
    );

    cpu_core CPU_ (
        .clk           (clk),
        .rst           (reset),
        .bus           (bus.master),
`ifdef INSTR_COUNT_EN
        .instr_count_o (instr_count),
`endif
        .halted_o      (halted)
    );
endmodule

// File: tb/tb_cpu_machine.sv
// -----------------------------------------------------------------------------
// tb_cpu_machine
//   Directed programs with hand-computed results for cpu_machine. Programs and
//   data are written straight into the memory arrays; results are read from
//   the register file, flags, PC, data memory and the halted output.
//   Define INSTR_COUNT_EN for both bench and RTL to cover the counter.
// -----------------------------------------------------------------------------
module tb_cpu_machine;
    logic clk;
    logic reset;
    logic halted;
`ifdef INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    int total = 0;
    int bad   = 0;
    int edges;

    localparam logic [2:0] R_A = 3'd0, R_B = 3'd1, R_C = 3'd2, R_D = 3'd3,
                           R_E = 3'd4, R_F = 3'd5, R_G = 3'd6, R_H = 3'd7;

    cpu_machine dut (
        .clk         (clk),
        .reset       (reset),
`ifdef INSTR_COUNT_EN
        .instr_count (instr_count),
`endif
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ri(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
        return {op, rd, 1'b0, imm};
    endfunction

    function automatic logic [15:0] rr(input logic [3:0] op, input logic [2:0] rd, input logic [2:0] rs);
        return {op, rd, rs, 6'd0};
    endfunction

    function automatic logic [7:0] reg_val(input int i);
        case (i)
            0: return dut.CPU_.CPU_regs.regA;
            1: return dut.CPU_.CPU_regs.regB;
            2: return dut.CPU_.CPU_regs.regC;
            3: return dut.CPU_.CPU_regs.regD;
            4: return dut.CPU_.CPU_regs.regE;
            5: return dut.CPU_.CPU_regs.regF;
            6: return dut.CPU_.CPU_regs.regG;
            default: return dut.CPU_.CPU_regs.regH;
        endcase
    endfunction

    task automatic check_regs(input string tag, input logic [7:0] exp [8]);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_r%0d", tag, i), {24'd0, reg_val(i)}, {24'd0, exp[i]});
        end
    endtask

    // Every address not used by a program holds HLT; data memory is zeroed.
    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            dut.I_MEM.Memory[i] = 16'hF000;
            dut.D_MEM.Memory[i] = 8'h00;
        end
    endtask

    task automatic start();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Counts rising edges until halted, bounded so a broken core cannot hang.
    task automatic run_to_halt(input string tag, output int n);
        n = 0;
        while (!halted && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!halted) check({tag, "_halt_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        logic [7:0] exp_r [8];
        reset = 1'b1;

        // ---- program 1: LDI/ADD basics and reset state ----
        clear_mem();
        dut.I_MEM.Memory[0] = ri(4'h1, R_A, 8'd5);
        dut.I_MEM.Memory[1] = ri(4'h1, R_B, 8'd7);
        dut.I_MEM.Memory[2] = rr(4'h3, R_A, R_B);
        dut.I_MEM.Memory[3] = 16'hF000;
        #1;
        exp_r = '{default: 8'd0};
        check_regs("rst", exp_r);
        check("rst_pc", {24'd0, dut.CPU_.pc_q}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_z", {31'd0, dut.CPU_.z_q}, 32'd0);
        check("rst_c", {31'd0, dut.CPU_.c_q}, 32'd0);
        start();
        run_to_halt("p1", edges);
        check("p1_edges", edges, 32'd4);
        exp_r = '{8'd12, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        check_regs("p1", exp_r);
        check("p1_z", {31'd0, dut.CPU_.z_q}, 32'd0);
        check("p1_c", {31'd0, dut.CPU_.c_q}, 32'd0);
        check("p1_pc", {24'd0, dut.CPU_.pc_q}, 32'd3);

        // ---- program 2: carry out and taken JC ----
        clear_mem();
        dut.I_MEM.Memory[0] = ri(4'h1, R_A, 8'd200);
        dut.I_MEM.Memory[1] = ri(4'h1, R_B, 8'd100);
        dut.I_MEM.Memory[2] = rr(4'h3, R_A, R_B);
        dut.I_MEM.Memory[3] = ri(4'hE, 3'd0, 8'd6);
        dut.I_MEM.Memory[4] = ri(4'h1, R_H, 8'd1);
        dut.I_MEM.Memory[5] = 16'hF000;
        dut.I_MEM.Memory[6] = ri(4'h1, R_G, 8'd9);
        dut.I_MEM.Memory[7] = 16'hF000;
        start();
        run_to_halt("p2", edges);
        check("p2_edges", edges, 32'd6);
        exp_r = '{8'd44, 8'd100, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9, 8'd0};
        check_regs("p2", exp_r);
        check("p2_c", {31'd0, dut.CPU_.c_q}, 32'd1);
        check("p2_z", {31'd0, dut.CPU_.z_q}, 32'd0);
        check("p2_pc", {24'd0, dut.CPU_.pc_q}, 32'd7);

        // ---- program 3: SUB/JZ/JMP loop ----
        clear_mem();
        dut.I_MEM.Memory[0] = ri(4'h1, R_A, 8'd3);
        dut.I_MEM.Memory[1] = ri(4'h1, R_B, 8'd1);
        dut.I_MEM.Memory[2] = rr(4'h4, R_A, R_B);
        dut.I_MEM.Memory[3] = ri(4'hD, 3'd0, 8'd5);
        dut.I_MEM.Memory[4] = ri(4'hC, 3'd0, 8'd2);
        dut.I_MEM.Memory[5] = 16'hF000;
        start();
        run_to_halt("p3", edges);
        check("p3_edges", edges, 32'd11);
        check("p3_a", {24'd0, reg_val(0)}, 32'd0);
        check("p3_b", {24'd0, reg_val(1)}, 32'd1);
        check("p3_z", {31'd0, dut.CPU_.z_q}, 32'd1);
        check("p3_c", {31'd0, dut.CPU_.c_q}, 32'd0);
        check("p3_pc", {24'd0, dut.CPU_.pc_q}, 32'd5);
`ifdef INSTR_COUNT_EN
        check("p3_icount", {16'd0, instr_count}, 32'd11);
`endif

        // ---- async reset mid-loop (program 3 still loaded) ----
        start();
        repeat (5) @(negedge clk);
        check("mid_a_before", {24'd0, reg_val(0)}, 32'd2);
        check("mid_pc_before", {24'd0, dut.CPU_.pc_q}, 32'd2);
        #2 reset = 1'b1;
        #1;
        check("mid_pc_async", {24'd0, dut.CPU_.pc_q}, 32'd0);
        check("mid_a_async", {24'd0, reg_val(0)}, 32'd0);
        check("mid_b_async", {24'd0, reg_val(1)}, 32'd0);
        check("mid_z_async", {31'd0, dut.CPU_.z_q}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_to_halt("mid", edges);
        check("mid_edges", edges, 32'd11);
        check("mid_a_final", {24'd0, reg_val(0)}, 32'd0);

        // ---- program 4: LD/STR/LDR, then halt freeze and reset/rerun ----
        clear_mem();
        dut.D_MEM.Memory[8'h10] = 8'h2A;
        dut.I_MEM.Memory[0] = ri(4'h8, R_C, 8'h10);
        dut.I_MEM.Memory[1] = ri(4'h1, R_D, 8'h20);
        dut.I_MEM.Memory[2] = rr(4'hB, R_C, R_D);
        dut.I_MEM.Memory[3] = rr(4'hA, R_E, R_D);
        dut.I_MEM.Memory[4] = 16'hF000;
        start();
        run_to_halt("p4", edges);
        check("p4_edges", edges, 32'd5);
        check("p4_dmem20", {24'd0, dut.D_MEM.Memory[8'h20]}, 32'h2A);
        check("p4_e", {24'd0, reg_val(4)}, 32'd42);
        repeat (20) @(negedge clk);
        exp_r = '{8'd0, 8'd0, 8'h2A, 8'h20, 8'h2A, 8'd0, 8'd0, 8'd0};
        check_regs("frz", exp_r);
        check("frz_pc", {24'd0, dut.CPU_.pc_q}, 32'd4);
        check("frz_halted", {31'd0, halted}, 32'd1);
        check("frz_dmem20", {24'd0, dut.D_MEM.Memory[8'h20]}, 32'h2A);
`ifdef INSTR_COUNT_EN
        check("frz_icount", {16'd0, instr_count}, 32'd5);
`endif
        reset = 1'b1;
        #1;
        exp_r = '{default: 8'd0};
        check_regs("rst2", exp_r);
        check("rst2_halted", {31'd0, halted}, 32'd0);
        check("rst2_pc", {24'd0, dut.CPU_.pc_q}, 32'd0);
        check("rst2_dmem_kept", {24'd0, dut.D_MEM.Memory[8'h20]}, 32'h2A);
`ifdef INSTR_COUNT_EN
        check("rst2_icount", {16'd0, instr_count}, 32'd0);
`endif
        dut.D_MEM.Memory[8'h20] = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        run_to_halt("rerun", edges);
        check("rerun_edges", edges, 32'd5);
        check("rerun_e", {24'd0, reg_val(4)}, 32'd42);
        check("rerun_dmem20", {24'd0, dut.D_MEM.Memory[8'h20]}, 32'h2A);

        // ---- program 5: rd==rs, MOV, borrow, logic ops, ST/LD, untaken JC ----
        clear_mem();
        dut.I_MEM.Memory[0]  = ri(4'h1, R_A, 8'h81);
        dut.I_MEM.Memory[1]  = rr(4'h3, R_A, R_A);
        dut.I_MEM.Memory[2]  = rr(4'h2, R_B, R_A);
        dut.I_MEM.Memory[3]  = ri(4'h1, R_C, 8'h0F);
        dut.I_MEM.Memory[4]  = rr(4'h4, R_B, R_C);
        dut.I_MEM.Memory[5]  = ri(4'h1, R_D, 8'hF0);
        dut.I_MEM.Memory[6]  = rr(4'h6, R_D, R_C);
        dut.I_MEM.Memory[7]  = rr(4'h5, R_C, R_D);
        dut.I_MEM.Memory[8]  = ri(4'h9, R_D, 8'h30);
        dut.I_MEM.Memory[9]  = ri(4'h8, R_F, 8'h30);
        dut.I_MEM.Memory[10] = rr(4'h7, R_F, R_D);
        dut.I_MEM.Memory[11] = ri(4'hE, 3'd0, 8'h00);
        dut.I_MEM.Memory[12] = 16'hF000;
        start();
        @(negedge clk);
        @(negedge clk);
        check("p5_add_self", {24'd0, reg_val(0)}, 32'h02);
        check("p5_add_self_c", {31'd0, dut.CPU_.c_q}, 32'd1);
        run_to_halt("p5", edges);
        check("p5_edges", edges + 2, 32'd13);
        exp_r = '{8'h02, 8'hF3, 8'h0F, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        check_regs("p5", exp_r);
        check("p5_z", {31'd0, dut.CPU_.z_q}, 32'd1);
        check("p5_c", {31'd0, dut.CPU_.c_q}, 32'd0);
        check("p5_dmem30", {24'd0, dut.D_MEM.Memory[8'h30]}, 32'hFF);
        check("p5_pc", {24'd0, dut.CPU_.pc_q}, 32'd12);

        // ---- program 6: PC wrap 255 -> 0, untaken then taken JZ ----
        clear_mem();
        dut.I_MEM.Memory[0]    = ri(4'hD, 3'd0, 8'd3);
        dut.I_MEM.Memory[1]    = ri(4'hC, 3'd0, 8'hFE);
        dut.I_MEM.Memory[2]    = 16'hF000;
        dut.I_MEM.Memory[3]    = 16'hF000;
        dut.I_MEM.Memory[8'hFE] = ri(4'h1, R_A, 8'd1);
        dut.I_MEM.Memory[8'hFF] = rr(4'h4, R_A, R_A);
        start();
        run_to_halt("p6", edges);
        check("p6_edges", edges, 32'd6);
        check("p6_pc", {24'd0, dut.CPU_.pc_q}, 32'd3);
        check("p6_a", {24'd0, reg_val(0)}, 32'd0);
        check("p6_z", {31'd0, dut.CPU_.z_q}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
